// File: rtl/axi_slice_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_slice_pkg
//  Description : Shared types for the AXI channel buffers. Holds the
//                response encoding used by the R and B channels. Beat structs
//                depend on module parameters and are declared in each buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_slice_pkg;

    // AXI response encoding (RRESP / BRESP)
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    // Pointer width for a circular buffer of the given depth (at least 1 bit)
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : axi_slice_pkg
`default_nettype wire

// File: rtl/fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ptr_ctrl
//  Description : Read/write pointer and occupancy control for a circular FIFO
//                of arbitrary depth (not limited to powers of two). Pointers
//                wrap by explicit compare against DEPTH-1.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_push, i_pop  - qualified write / read strobes
//                o_wr_ptr       - slot written by the next push
//                o_rd_ptr       - slot presented at the head
//                o_count        - number of stored entries
//                o_full/o_empty - occupancy flags from the registered count
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr_ctrl
    import axi_slice_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = ptr_width(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    output logic [PTR_W-1:0] o_wr_ptr,
    output logic [PTR_W-1:0] o_rd_ptr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [PTR_W-1:0] c_LAST_SLOT = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_DEPTH     = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_SLOT) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_SLOT) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged
            if (i_push && !i_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (i_pop && !i_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_wr_ptr = r_wr_ptr;
    assign o_rd_ptr = r_rd_ptr;
    assign o_count  = r_count;
    assign o_full   = (r_count == c_DEPTH);
    assign o_empty  = (r_count == '0);

endmodule : fifo_ptr_ctrl
`default_nettype wire

// File: rtl/axi_r_fifo_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : axi_r_fifo_buffer
//  Description : AXI4 read-data (R) channel elastic buffer. Beats from the
//                slave side are stored in a circular FIFO and presented to the
//                master side one cycle later, in accept order. Counts stored
//                beats carrying RLAST. slave_ready_o depends only on the
//                registered occupancy, so there is no combinational path from
//                master_ready_i.
//  Ports       : clk_i, rst_i      - clock, synchronous active-high reset
//                test_en_i         - test mode, functionally ignored
//                slave_*           - upstream R beat and handshake
//                master_*          - downstream R beat (FIFO head) and handshake
//                burst_cnt_o       - number of stored beats with last=1
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_r_fifo_buffer
    import axi_slice_pkg::*;
#(
    parameter int ID_WIDTH     = 4,
    parameter int DATA_WIDTH   = 64,
    parameter int USER_WIDTH   = 1,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              test_en_i,
    input  logic                              slave_valid_i,
    input  logic [ID_WIDTH-1:0]               slave_id_i,
    input  logic [DATA_WIDTH-1:0]             slave_data_i,
    input  logic [1:0]                        slave_resp_i,
    input  logic [USER_WIDTH-1:0]             slave_user_i,
    input  logic                              slave_last_i,
    output logic                              slave_ready_o,
    output logic                              master_valid_o,
    output logic [ID_WIDTH-1:0]               master_id_o,
    output logic [DATA_WIDTH-1:0]             master_data_o,
    output logic [1:0]                        master_resp_o,
    output logic [USER_WIDTH-1:0]             master_user_o,
    output logic                              master_last_o,
    input  logic                              master_ready_i,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0] burst_cnt_o
);

    localparam int c_PTR_W = ptr_width(BUFFER_DEPTH);
    localparam int c_CNT_W = $clog2(BUFFER_DEPTH + 1);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        axi_resp_t             resp;
        logic [USER_WIDTH-1:0] user;
        logic                  last;
    } r_beat_t;

    r_beat_t              r_mem [BUFFER_DEPTH];
    r_beat_t              w_in_beat;
    r_beat_t              w_head;
    logic [c_PTR_W-1:0]   w_wr_ptr;
    logic [c_PTR_W-1:0]   w_rd_ptr;
    logic [c_CNT_W-1:0]   w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [c_CNT_W-1:0]   r_burst_cnt;
    logic                 w_unused;

    assign w_unused = test_en_i;

    // Handshake flags are forced low while reset is held
    assign slave_ready_o  = ~rst_i & ~w_full;
    assign master_valid_o = ~rst_i & ~w_empty;
    assign w_push         = slave_valid_i & slave_ready_o;
    assign w_pop          = master_valid_o & master_ready_i;

    fifo_ptr_ctrl #(
        .DEPTH (BUFFER_DEPTH),
        .PTR_W (c_PTR_W),
        .CNT_W (c_CNT_W)
    ) u_ptr_ctrl (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .o_wr_ptr (w_wr_ptr),
        .o_rd_ptr (w_rd_ptr),
        .o_count  (w_count),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    assign w_in_beat.id   = slave_id_i;
    assign w_in_beat.data = slave_data_i;
    assign w_in_beat.resp = axi_resp_t'(slave_resp_i);
    assign w_in_beat.user = slave_user_i;
    assign w_in_beat.last = slave_last_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BUFFER_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[w_wr_ptr] <= w_in_beat;
        end
    end

    // Head slot is presented directly; it cannot change until popped since
    // a push never targets the read slot while entries remain stored.
    assign w_head         = r_mem[w_rd_ptr];
    assign master_id_o    = w_head.id;
    assign master_data_o  = w_head.data;
    assign master_resp_o  = w_head.resp;
    assign master_user_o  = w_head.user;
    assign master_last_o  = w_head.last;

    // Stored complete bursts: one per buffered beat with last set
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_burst_cnt <= '0;
        end else begin
            case ({w_push & slave_last_i, w_pop & master_last_o})
                2'b10:   r_burst_cnt <= r_burst_cnt + c_CNT_W'(1);
                2'b01:   r_burst_cnt <= r_burst_cnt - c_CNT_W'(1);
                default: r_burst_cnt <= r_burst_cnt;
            endcase
        end
    end

    assign burst_cnt_o = r_burst_cnt;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(w_push && w_full))
                else $error("axi_r_fifo_buffer: push while full");
            assert (!(w_pop && w_empty))
                else $error("axi_r_fifo_buffer: pop while empty");
            assert (r_burst_cnt <= w_count)
                else $error("axi_r_fifo_buffer: burst count exceeds occupancy");
        end
    end
`endif

endmodule : axi_r_fifo_buffer
`default_nettype wire

// File: tb/tb_axi_r_fifo_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_r_fifo_buffer
//  Description : Self-checking bench for axi_r_fifo_buffer. Two instances:
//                depth 4 and depth 3. A queue per instance models the FIFO;
//                beats are packed as {id[4], data[64], resp[2], user[1], last}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_r_fifo_buffer;

    logic clk;
    logic rst;

    logic        s4_valid, m4_ready, s4_ready, m4_valid, m4_last;
    logic [71:0] b4_in;
    logic [3:0]  m4_id;
    logic [63:0] m4_data;
    logic [1:0]  m4_resp;
    logic [0:0]  m4_user;
    logic [2:0]  m4_burst;

    logic        s3_valid, m3_ready, s3_ready, m3_valid, m3_last;
    logic [71:0] b3_in;
    logic [3:0]  m3_id;
    logic [63:0] m3_data;
    logic [1:0]  m3_resp;
    logic [0:0]  m3_user;
    logic [1:0]  m3_burst;

    logic [71:0] q4[$];
    logic [71:0] q3[$];

    int n_checks = 0;
    int n_pass   = 0;

    wire [71:0] head4 = {m4_id, m4_data, m4_resp, m4_user, m4_last};
    wire [71:0] head3 = {m3_id, m3_data, m3_resp, m3_user, m3_last};

    axi_r_fifo_buffer #(.ID_WIDTH(4), .DATA_WIDTH(64), .USER_WIDTH(1), .BUFFER_DEPTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .test_en_i(1'b0),
        .slave_valid_i(s4_valid), .slave_id_i(b4_in[71:68]), .slave_data_i(b4_in[67:4]),
        .slave_resp_i(b4_in[3:2]), .slave_user_i(b4_in[1:1]), .slave_last_i(b4_in[0]),
        .slave_ready_o(s4_ready), .master_valid_o(m4_valid), .master_id_o(m4_id),
        .master_data_o(m4_data), .master_resp_o(m4_resp), .master_user_o(m4_user),
        .master_last_o(m4_last), .master_ready_i(m4_ready), .burst_cnt_o(m4_burst)
    );

    axi_r_fifo_buffer #(.ID_WIDTH(4), .DATA_WIDTH(64), .USER_WIDTH(1), .BUFFER_DEPTH(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .test_en_i(1'b0),
        .slave_valid_i(s3_valid), .slave_id_i(b3_in[71:68]), .slave_data_i(b3_in[67:4]),
        .slave_resp_i(b3_in[3:2]), .slave_user_i(b3_in[1:1]), .slave_last_i(b3_in[0]),
        .slave_ready_o(s3_ready), .master_valid_o(m3_valid), .master_id_o(m3_id),
        .master_data_o(m3_data), .master_resp_o(m3_resp), .master_user_o(m3_user),
        .master_last_o(m3_last), .master_ready_i(m3_ready), .burst_cnt_o(m3_burst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [71:0] rand_beat(input logic [63:0] data, input logic last);
        return {4'($urandom), data, 2'($urandom), 1'($urandom), last};
    endfunction

    // Number of stored beats carrying last, i.e. the expected burst count
    function automatic int bursts4();
        int n = 0;
        foreach (q4[i]) if (q4[i][0]) n++;
        return n;
    endfunction

    // One clock: inputs are set at the negedge, model follows the FIFO rules
    task automatic tick();
        bit p4, o4, p3, o3;
        p4 = !rst && s4_valid && (q4.size() < 4);
        o4 = !rst && m4_ready && (q4.size() > 0);
        p3 = !rst && s3_valid && (q3.size() < 3);
        o3 = !rst && m3_ready && (q3.size() > 0);
        @(posedge clk);
        if (rst) begin
            q4.delete();
            q3.delete();
        end else begin
            if (o4) void'(q4.pop_front());
            if (p4) q4.push_back(b4_in);
            if (o3) void'(q3.pop_front());
            if (p3) q3.push_back(b3_in);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (s4_ready !== 1'b0) $display("FAIL rst_held_ready: got %b exp 0", s4_ready); else n_pass++;
        n_checks++; if (m4_valid !== 1'b0) $display("FAIL rst_held_valid: got %b exp 0", m4_valid); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (s4_ready !== 1'b1) $display("FAIL rst_ready: got %b exp 1", s4_ready); else n_pass++;
        n_checks++; if (m4_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", m4_valid); else n_pass++;
        n_checks++; if (m4_burst !== 3'd0) $display("FAIL rst_burst: got %0d exp 0", m4_burst); else n_pass++;
        n_checks++; if (head4 !== 72'd0) $display("FAIL rst_payload: got %h exp 0", head4); else n_pass++;
        n_checks++; if (s3_ready !== 1'b1) $display("FAIL rst_ready3: got %b exp 1", s3_ready); else n_pass++;
        tick();
        n_checks++; if (m4_valid !== 1'b0) $display("FAIL idle_valid: got %b exp 0", m4_valid); else n_pass++;
    endtask

    task automatic test_fill_drain();
        logic [63:0] d;
        m4_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s4_valid = 1'b1;
            b4_in    = rand_beat(64'h11 * (i + 1), 1'b0);
            tick();
        end
        n_checks++; if (s4_ready !== 1'b0) $display("FAIL full_ready: got %b exp 0", s4_ready); else n_pass++;
        b4_in = rand_beat(64'h55, 1'b0);
        tick();  // offered while full, must be refused
        s4_valid = 1'b0;
        m4_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 64'h11 * (i + 1);
            n_checks++; if (m4_valid !== 1'b1) $display("FAIL drain_valid[%0d]: got %b exp 1", i, m4_valid); else n_pass++;
            n_checks++; if (m4_data !== d) $display("FAIL drain_data[%0d]: got %h exp %h", i, m4_data, d); else n_pass++;
            n_checks++; if (head4 !== q4[0]) $display("FAIL drain_beat[%0d]: got %h exp %h", i, head4, q4[0]); else n_pass++;
            tick();
        end
        n_checks++; if (m4_valid !== 1'b0) $display("FAIL drain_empty: got %b exp 0", m4_valid); else n_pass++;
        m4_ready = 1'b0;
    endtask

    task automatic test_stream();
        logic [71:0] beats[16];
        foreach (beats[i]) beats[i] = rand_beat({$urandom, $urandom}, 1'($urandom));
        m4_ready = 1'b1;
        s4_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b4_in = beats[i];
            if (i == 0) begin
                n_checks++; if (m4_valid !== 1'b0) $display("FAIL stream_latency: got %b exp 0", m4_valid); else n_pass++;
            end else begin
                n_checks++; if (m4_valid !== 1'b1 || s4_ready !== 1'b1)
                    $display("FAIL stream_flags[%0d]: got v=%b r=%b exp 1 1", i, m4_valid, s4_ready); else n_pass++;
                n_checks++; if (head4 !== beats[i-1])
                    $display("FAIL stream_beat[%0d]: got %h exp %h", i, head4, beats[i-1]); else n_pass++;
            end
            tick();
        end
        s4_valid = 1'b0;
        n_checks++; if (head4 !== beats[15] || m4_valid !== 1'b1)
            $display("FAIL stream_tail: got %h v=%b exp %h v=1", head4, m4_valid, beats[15]); else n_pass++;
        tick();
        n_checks++; if (m4_valid !== 1'b0) $display("FAIL stream_empty: got %b exp 0", m4_valid); else n_pass++;
        m4_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [71:0] beats[10];
        int in_idx = 0;
        int out_idx = 0;
        int cyc = 0;
        foreach (beats[i]) beats[i] = rand_beat({$urandom, $urandom}, 1'($urandom));
        while (out_idx < 10 && cyc < 400) begin
            s3_valid = (in_idx < 10) && ($urandom_range(3, 0) != 0);
            b3_in    = (in_idx < 10) ? beats[in_idx] : 72'd0;
            m3_ready = 1'($urandom);
            n_checks++; if (s3_ready !== (q3.size() < 3) || m3_valid !== (q3.size() > 0))
                $display("FAIL wrap_flags[%0d]: got r=%b v=%b exp r=%b v=%b", cyc, s3_ready, m3_valid,
                         q3.size() < 3, q3.size() > 0); else n_pass++;
            if (m3_ready && q3.size() > 0) begin
                n_checks++; if (head3 !== beats[out_idx])
                    $display("FAIL wrap_beat[%0d]: got %h exp %h", out_idx, head3, beats[out_idx]); else n_pass++;
                out_idx++;
            end
            if (s3_valid && q3.size() < 3) in_idx++;
            tick();
            cyc++;
        end
        n_checks++; if (out_idx != 10) $display("FAIL wrap_timeout: got %0d beats exp 10", out_idx); else n_pass++;
        s3_valid = 1'b0;
        m3_ready = 1'b0;
    endtask

    task automatic test_bursts();
        m4_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s4_valid = 1'b1;
            b4_in    = rand_beat({$urandom, $urandom}, (i % 2) == 1);
            tick();
        end
        s4_valid = 1'b0;
        n_checks++; if (m4_burst !== 3'(bursts4()) || bursts4() != 2)
            $display("FAIL burst_two: got %0d exp 2", m4_burst); else n_pass++;
        m4_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (m4_burst !== 3'(bursts4()) || bursts4() != 1)
            $display("FAIL burst_one: got %0d exp 1", m4_burst); else n_pass++;
        tick();  // removes the non-last third beat; head is now a last beat
        n_checks++; if (m4_last !== 1'b1) $display("FAIL burst_head_last: got %b exp 1", m4_last); else n_pass++;
        s4_valid = 1'b1;
        b4_in    = rand_beat({$urandom, $urandom}, 1'b1);
        tick();  // push-last and pop-last together
        s4_valid = 1'b0;
        n_checks++; if (m4_burst !== 3'(bursts4()) || bursts4() != 1)
            $display("FAIL burst_both: got %0d exp 1", m4_burst); else n_pass++;
        n_checks++; if (head4 !== q4[0]) $display("FAIL burst_head: got %h exp %h", head4, q4[0]); else n_pass++;
        tick();
        n_checks++; if (m4_burst !== 3'd0 || m4_valid !== 1'b0)
            $display("FAIL burst_drained: got %0d v=%b exp 0 v=0", m4_burst, m4_valid); else n_pass++;
        m4_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        m4_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s4_valid = 1'b1;
            b4_in    = rand_beat({$urandom, $urandom}, 1'b1);
            tick();
        end
        s4_valid = 1'b0;
        n_checks++; if (m4_burst !== 3'd3) $display("FAIL mid_pre_burst: got %0d exp 3", m4_burst); else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++; if (m4_valid !== 1'b0 || s4_ready !== 1'b0)
            $display("FAIL mid_rst_flags: got v=%b r=%b exp 0 0", m4_valid, s4_ready); else n_pass++;
        n_checks++; if (m4_burst !== 3'd0) $display("FAIL mid_rst_burst: got %0d exp 0", m4_burst); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (s4_ready !== 1'b1 || m4_valid !== 1'b0)
            $display("FAIL mid_release: got r=%b v=%b exp 1 0", s4_ready, m4_valid); else n_pass++;
        // Refill to full: exactly four accepts proves the occupancy restarted at zero
        m4_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s4_valid = 1'b1;
            b4_in    = rand_beat({$urandom, $urandom}, 1'b0);
            tick();
            n_checks++; if (s4_ready !== (q4.size() < 4))
                $display("FAIL mid_refill[%0d]: got %b exp %b", i, s4_ready, q4.size() < 4); else n_pass++;
        end
        s4_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        s4_valid = 1'b0; m4_ready = 1'b0; b4_in = '0;
        s3_valid = 1'b0; m3_ready = 1'b0; b3_in = '0;
        @(negedge clk);
        test_reset();
        test_fill_drain();
        test_stream();
        test_wrap();
        test_bursts();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_axi_r_fifo_buffer
`default_nettype wire
